// File: rtl/strb_ram_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ram_pkg : shared FSM state type, lane helpers and strobe merge function
// Rev 1.0
// ---------------------------------------------------------------------------
package ram_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD      = 3'd1,
      RD_RESP = 3'd2,
      RMW_RD  = 3'd3,
      RMW_WR  = 3'd4,
      WR      = 3'd5,
      WR_RESP = 3'd6
   } state_t;

   // Widest word the merge function handles; callers cast to their own width.
   localparam int MAX_W     = 1024;
   localparam int MAX_LANES = MAX_W / 8;

   function automatic int lanes(input int data_w);
      return data_w / 8;
   endfunction

   function automatic int lsb_bits(input int data_w);
      return $clog2(data_w / 8);
   endfunction

   function automatic logic [MAX_W-1:0] merge(input logic [MAX_LANES-1:0] strb,
                                              input logic [MAX_W-1:0]     wnew,
                                              input logic [MAX_W-1:0]     wold);
      logic [MAX_W-1:0] res;
      for (int i = 0; i < MAX_LANES; i++)
         res[8*i +: 8] = strb[i] ? wnew[8*i +: 8] : wold[8*i +: 8];
      return res;
   endfunction

endpackage
`default_nettype wire

// File: rtl/strb_ram_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// strb_ram_ctrl_if : request/response bundle between bus matrix and RAM ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
interface strb_ram_ctrl_if #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 64
);
   logic                  WriteEnable;
   logic [ADDR_W-1:0]     WriteAddr;
   logic [DATA_W-1:0]     WriteData;
   logic [DATA_W/8-1:0]   WriteStrb;
   logic                  ReadEnable;
   logic [ADDR_W-1:0]     ReadAddr;
   logic [DATA_W-1:0]     ReadData;
   logic                  ReadReady;
   logic                  WriteReady;
   logic                  RespErr;

   modport master (
      output WriteEnable, WriteAddr, WriteData, WriteStrb, ReadEnable, ReadAddr,
      input  ReadData, ReadReady, WriteReady, RespErr
   );

   modport slave (
      input  WriteEnable, WriteAddr, WriteData, WriteStrb, ReadEnable, ReadAddr,
      output ReadData, ReadReady, WriteReady, RespErr
   );
endinterface
`default_nettype wire

// File: rtl/strb_ram_ctrl_sync_dp_ram.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sync_dp_ram : one write port, one registered read port, no array reset
// Rev 1.0
// ---------------------------------------------------------------------------
module sync_dp_ram #(
   parameter int DATA_W     = 64,
   parameter int DEPTH_LOG2 = 12
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [DEPTH_LOG2-1:0] waddr,
   input  logic [DATA_W-1:0]     wdata,
   input  logic                  re,
   input  logic [DEPTH_LOG2-1:0] raddr,
   output logic [DATA_W-1:0]     rdata
);
   logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
      if (re)
         rdata <= mem[raddr];
   end
endmodule
`default_nettype wire

// File: rtl/strb_ram_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// strb_ram_ctrl : byte-strobed RAM controller with RMW, range check, errors
// Rev 1.0
// ---------------------------------------------------------------------------
module strb_ram_ctrl
   import ram_pkg::*;
#(
   parameter int                DATA_W     = 64,
   parameter int                ADDR_W     = 64,
   parameter int                DEPTH_LOG2 = 12,
   parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(64'h8000_0000)
) (
   input  logic            ACLK,
   input  logic            ARESETn,
   strb_ram_ctrl_if.slave  bus
);
   localparam int              LANES    = lanes(DATA_W);
   localparam int              LSB      = lsb_bits(DATA_W);
   localparam logic [ADDR_W:0] BASE_EXT = {1'b0, BASE_ADDR};
   localparam logic [ADDR_W:0] SPAN     = (ADDR_W+1)'(1) << (DEPTH_LOG2 + LSB);
   localparam logic [ADDR_W:0] LIMIT    = BASE_EXT + SPAN;

   state_t                  state;
   logic [DEPTH_LOG2-1:0]   st_idx;
   logic [DATA_W-1:0]       st_data;
   logic [LANES-1:0]        st_strb;
   logic                    st_err;

   logic                    wr_ok, rd_ok;
   logic [DEPTH_LOG2-1:0]   wr_idx, rd_idx;
   logic                    mem_we, mem_re;
   logic [DATA_W-1:0]       mem_wdata, mem_rdata, merged;

   // One extra bit so the upper bound never wraps at the top of address space.
   function automatic logic in_range(input logic [ADDR_W-1:0] addr);
      return ({1'b0, addr} >= BASE_EXT) && ({1'b0, addr} < LIMIT);
   endfunction

   function automatic logic [DEPTH_LOG2-1:0] word_idx(input logic [ADDR_W-1:0] addr);
      return DEPTH_LOG2'((addr - BASE_ADDR) >> LSB);
   endfunction

   assign wr_ok  = in_range(bus.WriteAddr);
   assign rd_ok  = in_range(bus.ReadAddr);
   assign wr_idx = word_idx(bus.WriteAddr);
   assign rd_idx = word_idx(bus.ReadAddr);

   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         state   <= IDLE;
         st_idx  <= '0;
         st_data <= '0;
         st_strb <= '0;
         st_err  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.WriteEnable) begin
                  st_idx  <= wr_idx;
                  st_data <= bus.WriteData;
                  st_strb <= bus.WriteStrb;
                  st_err  <= !wr_ok;
                  if (!wr_ok || (bus.WriteStrb == '0))
                     state <= WR_RESP;
                  else if (&bus.WriteStrb)
                     state <= WR;
                  else
                     state <= RMW_RD;
               end else if (bus.ReadEnable) begin
                  st_idx <= rd_idx;
                  st_err <= !rd_ok;
                  state  <= rd_ok ? RD : RD_RESP;
               end
            end
            RD:               state <= RD_RESP;
            RMW_RD:           state <= RMW_WR;
            RMW_WR, WR:       state <= WR_RESP;
            RD_RESP, WR_RESP: state <= IDLE;
            default:          state <= IDLE;
         endcase
      end
   end

   assign merged    = DATA_W'(merge(MAX_LANES'(st_strb), MAX_W'(st_data), MAX_W'(mem_rdata)));
   // Gating with ARESETn keeps an abandoned RMW from landing on the reset edge.
   assign mem_we    = ARESETn && ((state == WR) || (state == RMW_WR));
   assign mem_re    = (state == RD) || (state == RMW_RD);
   assign mem_wdata = (state == RMW_WR) ? merged : st_data;

   sync_dp_ram #(
      .DATA_W     (DATA_W),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_ram (
      .clk   (ACLK),
      .we    (mem_we),
      .waddr (st_idx),
      .wdata (mem_wdata),
      .re    (mem_re),
      .raddr (st_idx),
      .rdata (mem_rdata)
   );

   assign bus.ReadReady  = (state == RD_RESP);
   assign bus.WriteReady = (state == WR_RESP);
   assign bus.RespErr    = ((state == RD_RESP) || (state == WR_RESP)) && st_err;
   assign bus.ReadData   = ((state == RD_RESP) && !st_err) ? mem_rdata : '0;
endmodule
`default_nettype wire

// File: tb/tb_strb_ram_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_strb_ram_ctrl : directed + random bench against a word-array model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_strb_ram_ctrl;
   import ram_pkg::*;

   localparam int          DATA_W     = 64;
   localparam int          ADDR_W     = 64;
   localparam int          DEPTH_LOG2 = 10;
   localparam logic [63:0] BASE       = 64'h8000_0000;
   localparam logic [63:0] SPAN       = 64'd8192;

   logic ACLK    = 1'b0;
   logic ARESETn = 1'b0;
   int   total   = 0;
   int   bad     = 0;
   logic [63:0] model [int];

   strb_ram_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   strb_ram_ctrl #(
      .DATA_W     (DATA_W),
      .ADDR_W     (ADDR_W),
      .DEPTH_LOG2 (DEPTH_LOG2),
      .BASE_ADDR  (BASE)
   ) dut (
      .ACLK    (ACLK),
      .ARESETn (ARESETn),
      .bus     (bus)
   );

   always #5 ACLK = ~ACLK;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] ref_merge(input logic [7:0] strb, input logic [63:0] nw,
                                             input logic [63:0] old);
      logic [63:0] mask;
      mask = '0;
      for (int i = 0; i < 8; i++)
         if (strb[i]) mask = mask | (64'hFF << (8 * i));
      return (nw & mask) | (old & ~mask);
   endfunction

   function automatic bit in_rng(input logic [63:0] a);
      return (a >= BASE) && (a < BASE + SPAN);
   endfunction

   // Starts in the IDLE cycle after the previous response; lat counts edges to Ready.
   task automatic do_op(input bit is_wr, input logic [63:0] addr, input logic [63:0] data,
                        input logic [7:0] strb, output int lat, output logic err,
                        output logic [63:0] rd, output bit stray);
      @(posedge ACLK); #1;
      if (is_wr) begin
         bus.WriteEnable = 1'b1; bus.WriteAddr = addr; bus.WriteData = data; bus.WriteStrb = strb;
      end else begin
         bus.ReadEnable = 1'b1; bus.ReadAddr = addr;
      end
      lat = 0; stray = 1'b0;
      forever begin
         @(posedge ACLK); #1;
         lat++;
         if ((is_wr ? bus.WriteReady : bus.ReadReady) === 1'b1) break;
         if (bus.ReadData !== '0 || bus.RespErr !== 1'b0 ||
             bus.ReadReady !== 1'b0 || bus.WriteReady !== 1'b0) stray = 1'b1;
         if (lat >= 20) begin lat = -1; break; end
      end
      err = bus.RespErr;
      rd  = bus.ReadData;
      if ((is_wr ? bus.ReadReady : bus.WriteReady) !== 1'b0) stray = 1'b1;
      bus.WriteEnable = 1'b0;
      bus.ReadEnable  = 1'b0;
   endtask

   task automatic run_write(input string tag, input logic [63:0] addr, input logic [63:0] data,
                            input logic [7:0] strb);
      int lat, exp_lat, idx;
      logic err;
      logic [63:0] rd;
      bit stray, ok;
      ok = in_rng(addr);
      do_op(1'b1, addr, data, strb, lat, err, rd, stray);
      if (!ok || strb == 8'h00) exp_lat = 1;
      else if (strb == 8'hFF)   exp_lat = 2;
      else                      exp_lat = 3;
      chk({tag, "_lat"},   64'(lat),   64'(exp_lat));
      chk({tag, "_err"},   64'(err),   64'(!ok));
      chk({tag, "_stray"}, 64'(stray), 64'd0);
      if (ok && strb != 8'h00) begin
         idx = int'((addr - BASE) >> 3);
         model[idx] = ref_merge(strb, data, model.exists(idx) ? model[idx] : 64'd0);
      end
   endtask

   task automatic run_read(input string tag, input logic [63:0] addr, output logic [63:0] rd);
      int lat, idx;
      logic err;
      logic [63:0] exp_rd;
      bit stray, ok;
      ok = in_rng(addr);
      idx = int'((addr - BASE) >> 3);
      exp_rd = (ok && model.exists(idx)) ? model[idx] : 64'd0;
      do_op(1'b0, addr, 64'd0, 8'h00, lat, err, rd, stray);
      chk({tag, "_lat"},   64'(lat),   ok ? 64'd2 : 64'd1);
      chk({tag, "_err"},   64'(err),   64'(!ok));
      chk({tag, "_data"},  rd,         exp_rd);
      chk({tag, "_stray"}, 64'(stray), 64'd0);
   endtask

   initial begin
      logic [63:0] rd, a, d;
      logic [7:0]  s;
      int          cnt, rcnt;
      bit          early;

      bus.WriteEnable = 1'b0; bus.WriteAddr = '0; bus.WriteData = '0; bus.WriteStrb = '0;
      bus.ReadEnable  = 1'b0; bus.ReadAddr  = '0;

      repeat (3) @(posedge ACLK);
      #1;
      chk("rst_rready", 64'(bus.ReadReady),  64'd0);
      chk("rst_wready", 64'(bus.WriteReady), 64'd0);
      chk("rst_err",    64'(bus.RespErr),    64'd0);
      chk("rst_rdata",  bus.ReadData,        64'd0);
      chk("rst_state",  64'(dut.state),      64'(IDLE));
      ARESETn = 1'b1;

      for (int w = 0; w < 16; w++)
         run_write("init", BASE + 64'(8 * w), {$urandom, $urandom}, 8'hFF);

      // Full write then readback
      run_write("tp_full", 64'h8000_0010, 64'h1122334455667788, 8'hFF);
      run_read("tp_full_rd", 64'h8000_0010, rd);
      chk("tp_full_const", rd, 64'h1122334455667788);

      // Partial write lanes 0 and 7
      run_write("tp_part", 64'h8000_0010, 64'hAA000000000000BB, 8'h81);
      run_read("tp_part_rd", 64'h8000_0010, rd);
      chk("tp_part_const", rd, 64'hAA223344556677BB);

      // Write and read requested together: write first, read sees new data
      @(posedge ACLK); #1;
      bus.WriteEnable = 1'b1; bus.WriteAddr = 64'h8000_0010;
      bus.WriteData = 64'h00000000DEADBEEF; bus.WriteStrb = 8'h0F;
      bus.ReadEnable  = 1'b1; bus.ReadAddr  = 64'h8000_0010;
      model[2] = ref_merge(8'h0F, 64'h00000000DEADBEEF, model[2]);
      cnt = 0; early = 1'b0;
      while (bus.WriteReady !== 1'b1 && cnt < 20) begin
         @(posedge ACLK); #1; cnt++;
         if (bus.ReadReady !== 1'b0) early = 1'b1;
      end
      chk("both_wlat", 64'(cnt), 64'd3);
      chk("both_early_read", 64'(early), 64'd0);
      bus.WriteEnable = 1'b0;
      rcnt = 0;
      while (bus.ReadReady !== 1'b1 && rcnt < 20) begin
         @(posedge ACLK); #1; rcnt++;
      end
      chk("both_rlat", 64'(rcnt), 64'd3);
      chk("both_rdata", bus.ReadData, 64'hAA223344DEADBEEF);
      chk("both_rdata_model", bus.ReadData, model[2]);
      bus.ReadEnable = 1'b0;

      // Out-of-range accesses
      run_write("err_wr_end", 64'h8000_2000, 64'h0123456789ABCDEF, 8'hFF);
      run_read("err_rd_below", 64'h7FFF_FFF8, rd);
      run_read("err_word0_kept", BASE, rd);
      run_read("err_word2_kept", 64'h8000_0010, rd);

      // Zero strobe
      run_write("zero_strb", 64'h8000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
      run_read("zero_strb_rd", 64'h8000_0010, rd);
      chk("zero_strb_const", rd, 64'hAA223344DEADBEEF);

      // Reset during RMW_WR abandons the write
      @(posedge ACLK); #1;
      bus.WriteEnable = 1'b1; bus.WriteAddr = BASE + 64'd40;
      bus.WriteData = 64'hFFFF_FFFF_FFFF_FF5A; bus.WriteStrb = 8'h01;
      @(posedge ACLK); #1;
      bus.WriteEnable = 1'b0;
      @(posedge ACLK); #1;
      chk("rmw_wr_reached", 64'(dut.state), 64'(RMW_WR));
      ARESETn = 1'b0;
      @(posedge ACLK); #1;
      chk("mid_rst_rready", 64'(bus.ReadReady),  64'd0);
      chk("mid_rst_wready", 64'(bus.WriteReady), 64'd0);
      chk("mid_rst_err",    64'(bus.RespErr),    64'd0);
      chk("mid_rst_rdata",  bus.ReadData,        64'd0);
      chk("mid_rst_state",  64'(dut.state),      64'(IDLE));
      ARESETn = 1'b1;
      run_read("mid_rst_kept", BASE + 64'd40, rd);

      // Random traffic over the first 16 words plus occasional bad addresses
      for (int n = 0; n < 80; n++) begin
         int kind;
         kind = $urandom_range(0, 9);
         d = {$urandom, $urandom};
         if (kind == 0) begin
            case ($urandom_range(0, 3))
               0:       a = BASE - 64'd8 - 64'(8 * $urandom_range(0, 100));
               1:       a = BASE + SPAN + 64'($urandom_range(0, 4095));
               2:       a = 64'hFFFF_FFFF_FFFF_FFF8;
               default: a = 64'h0;
            endcase
            if ($urandom_range(0, 1) == 1) run_write("rnd_err_wr", a, d, 8'($urandom));
            else                           run_read("rnd_err_rd", a, rd);
         end else begin
            a = BASE + 64'(8 * $urandom_range(0, 15)) + 64'($urandom_range(0, 7));
            if (kind <= 4) begin
               run_read("rnd_rd", a, rd);
            end else begin
               case ($urandom_range(0, 5))
                  0:       s = 8'h00;
                  1:       s = 8'hFF;
                  default: s = 8'($urandom);
               endcase
               run_write("rnd_wr", a, d, s);
            end
         end
      end

      for (int w = 0; w < 16; w++)
         run_read("final_rd", BASE + 64'(8 * w), rd);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/strb_ram_ctrl.md
# strb_ram_ctrl

Parametrised single-agent RAM controller between the bus matrix and an on-chip synchronous dual-port memory. Supports arbitrary per-byte write strobes through an internal read-modify-write sequence, single-pass full-word writes, registered reads, and address range checking with an error response. It generalises the fixed 8/16/32/64-bit low-aligned write scheme to any lane mask, and to any data width and depth.

## Interface
Parameters:
- DATA_W, 64, data width in bits; multiple of 8, power of two, ≥ 16
- ADDR_W, 64, bus address width
- DEPTH_LOG2, 12, log2 of memory depth in words
- BASE_ADDR, 64'h8000_0000, byte address of word 0; aligned to DATA_W/8 × 2^DEPTH_LOG2

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  reset, synchronous, active-low
- WriteEnable  in  1  write request; held until WriteReady
- WriteAddr  in  ADDR_W  byte address
- WriteData  in  DATA_W  write data, lane i = bits [8i+7:8i]
- WriteStrb  in  DATA_W/8  per-byte lane enables
- ReadEnable  in  1  read request; held until ReadReady
- ReadAddr  in  ADDR_W  byte address
- ReadData  out  DATA_W  read data, valid only while ReadReady
- ReadReady  out  1  one-cycle read completion
- WriteReady  out  1  one-cycle write completion
- RespErr  out  1  qualifies ReadReady/WriteReady: address out of range

## Operation
- LSB = log2(DATA_W/8); word index = (Addr − BASE_ADDR) >> LSB; Addr[LSB−1:0] ignored.
- In range iff BASE_ADDR ≤ Addr < BASE_ADDR + (2^DEPTH_LOG2 << LSB); comparison in ADDR_W+1 bits, no wrap.
- FSM states: IDLE, RD, RD_RESP, RMW_RD, RMW_WR, WR, WR_RESP.
- IDLE samples requests; on accept, address, data, strobe and range flag are captured into store registers. Nothing is sampled outside IDLE.
- Write accepted in IDLE:
  - out of range → WR_RESP with RespErr.
  - strobe 0 → WR_RESP with no memory access.
  - strobe all ones → WR.
  - otherwise → RMW_RD.
- Read accepted in IDLE: out of range → RD_RESP with RespErr; otherwise → RD.
- RD: memory read enable → RD_RESP.
- RMW_RD: memory read of the stored word → RMW_WR.
- RMW_WR: write merged word, byte i = Strb[i] ? WriteData byte i : RData byte i → WR_RESP.
- WR: write stored data → WR_RESP.
- RD_RESP and WR_RESP assert their Ready for one cycle → IDLE.
- Both enables high in IDLE: write wins. Read stays pending and is accepted on the next IDLE cycle, so it returns the newly written data.
- Outputs decode from the state register.
  - ReadData = RData in RD_RESP without error, else 0.
  - RespErr = stored range flag in RD_RESP/WR_RESP, else 0.
- Memory write enable is gated with ARESETn, so no write occurs on a reset edge.

## Timing
- Accept cycle T (IDLE with enable high). Completion:
  - read: ReadReady at T+2
  - full write: WriteReady at T+2; memory updated at end of T+1
  - partial write: WriteReady at T+3
  - zero-strobe or error: Ready at T+1
- Requester must drop or change its request on the edge ending the Ready cycle. An enable still high in the following IDLE cycle is taken as a new request.
- Reset mid-operation: state → IDLE, all outputs 0 the next cycle, store registers cleared. Memory contents are preserved; any in-flight RMW is abandoned without a write.
- Reset values: ReadData 0, ReadReady 0, WriteReady 0, RespErr 0, state IDLE.
- Back-to-back throughput: one read per 3 cycles; one full write per 3 cycles.

## Structure
- Shared package ram_pkg holds:
  - state enum
  - lane-count/LSB localparam functions
  - the merge function (strobe, new, old) → word
- Sub-module sync_dp_ram:
  - one write port, one read port, 2^DEPTH_LOG2 × DATA_W
  - read data registered one cycle after read enable
  - no reset on the array
- strb_ram_ctrl contains the FSM, store registers, range check and output decode.

## Test plan
DATA_W=64, DEPTH_LOG2=10, BASE_ADDR=0x8000_0000.

- Full write 0x1122334455667788 to 0x8000_0010, strb 0xFF; read back → WriteReady at T+2, ReadReady at T+2, ReadData 0x1122334455667788, RespErr 0.
- Partial write on that word: strb 0x81, data 0xAA000000000000BB → WriteReady at T+3; readback 0xAA223344556677BB.
- Write and read both high, same address, strb 0x0F, data 0x00000000DEADBEEF → write completes first; read returns 0xAA223344DEADBEEF.
- Write to 0x8000_2000 (one past end), and read from 0x7FFF_FFF8 → Ready at T+1 with RespErr 1, ReadData 0, memory unchanged.
- Strobe 0x00 write → WriteReady at T+1, no memory change.
- ARESETn low during RMW_WR of strb 0x01 → outputs 0 the next cycle, FSM IDLE, target word still holds its old value.
